// File: rtl/tdm_frame_tx.sv
// tdm_frame_tx: collects one sample per channel per frame from a
// channel-interleaved stream into a shadow buffer, then serialises the whole
// set as a DSP-mode TDM frame (bit clock, one-bit frame sync, MSB-first data).
module tdm_frame_tx #(
    parameter int NR_CHANNELS = 3,
    parameter int INPUT_WIDTH = 24,
    parameter int NR_SLOTS    = 4,
    parameter int SLOT_WIDTH  = 32,
    parameter int HALF_DIV    = 4,
    localparam int CH_W = (NR_CHANNELS > 1) ? $clog2(NR_CHANNELS) : 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [INPUT_WIDTH-1:0] s_tx_d,
    input  logic [CH_W-1:0]        s_tx_ch,
    input  logic                   s_tx_dv,
    output logic                   s_tx_dr,
    output logic                   tdm_sclk,
    output logic                   tdm_fs,
    output logic                   tdm_sd,
    output logic                   tx_underrun,
    output logic                   tx_running
);

    localparam int FRAME_BITS = NR_SLOTS * SLOT_WIDTH;
    localparam int BIT_W      = (FRAME_BITS > 1) ? $clog2(FRAME_BITS) : 1;
    localparam int DIV_W      = (HALF_DIV > 1) ? $clog2(HALF_DIV) : 1;
    localparam int PAD        = SLOT_WIDTH - INPUT_WIDTH;

    typedef enum logic {IDLE, RUN} state_t;

    state_t                  state_reg, state_next;
    logic [NR_CHANNELS-1:0]  need_reg;
    logic [INPUT_WIDTH-1:0]  shadow_reg [NR_CHANNELS];
    logic [FRAME_BITS-1:0]   shift_reg;
    logic [DIV_W-1:0]        div_cnt_reg;
    logic [BIT_W-1:0]        bit_cnt_reg;
    logic                    sclk_reg;
    logic                    fs_reg;
    logic                    dr_reg;
    logic                    underrun_reg;

    logic [NR_CHANNELS-1:0]  accept_mask;
    logic [FRAME_BITS-1:0]   frame_load;
    logic                    half_wrap;
    logic                    fall_tick;
    logic                    frame_wrap;
    logic                    start_load;
    logic                    do_load;

    // A channel is accepted only while it is still requested this frame;
    // out-of-range channel numbers never match any lane.
    genvar gi;
    generate
        for (gi = 0; gi < NR_CHANNELS; gi++) begin : g_accept
            assign accept_mask[gi] = s_tx_dv && (s_tx_ch == CH_W'(gi)) && need_reg[gi];
        end
    endgenerate

    // Frame image: slot 0 sits at the MSB end so it is shifted out first.
    // A sample accepted on the load edge bypasses the shadow into this frame.
    generate
        for (gi = 0; gi < NR_SLOTS; gi++) begin : g_slot
            if (gi < NR_CHANNELS) begin : g_used
                assign frame_load[FRAME_BITS-1-gi*SLOT_WIDTH -: SLOT_WIDTH] =
                    SLOT_WIDTH'(accept_mask[gi] ? s_tx_d : shadow_reg[gi]) << PAD;
            end else begin : g_unused
                assign frame_load[FRAME_BITS-1-gi*SLOT_WIDTH -: SLOT_WIDTH] = '0;
            end
        end
    endgenerate

    assign half_wrap  = (div_cnt_reg == DIV_W'(HALF_DIV - 1));
    assign fall_tick  = (state_reg == RUN) && half_wrap && sclk_reg;
    assign frame_wrap = fall_tick && (bit_cnt_reg == BIT_W'(FRAME_BITS - 1));
    assign start_load = (state_reg == IDLE) && (need_reg == '0);
    assign do_load    = start_load || frame_wrap;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next state: leave IDLE once every channel has delivered a sample.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (start_load) state_next = RUN;
            RUN:     state_next = RUN;
            default: state_next = IDLE;
        endcase
    end

    // Sample capture into the shadow buffer and per-channel request flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            need_reg <= '1;
            dr_reg   <= 1'b0;
            for (int i = 0; i < NR_CHANNELS; i++) begin
                shadow_reg[i] <= '0;
            end
        end else begin
            dr_reg <= |accept_mask;
            for (int i = 0; i < NR_CHANNELS; i++) begin
                if (accept_mask[i]) begin
                    shadow_reg[i] <= s_tx_d;
                end
            end
            if (do_load) begin
                need_reg <= '1;
            end else begin
                need_reg <= need_reg & ~accept_mask;
            end
        end
    end

    // Bit-clock divider, bit counter, shift register and frame sync.
    always_ff @(posedge clk) begin
        if (rst) begin
            shift_reg    <= '0;
            div_cnt_reg  <= '0;
            bit_cnt_reg  <= '0;
            sclk_reg     <= 1'b0;
            fs_reg       <= 1'b0;
            underrun_reg <= 1'b0;
        end else begin
            underrun_reg <= 1'b0;
            if (start_load) begin
                shift_reg   <= frame_load;
                div_cnt_reg <= '0;
                bit_cnt_reg <= '0;
                sclk_reg    <= 1'b0;
                fs_reg      <= 1'b1;
            end else if (state_reg == RUN) begin
                if (half_wrap) begin
                    div_cnt_reg <= '0;
                    sclk_reg    <= ~sclk_reg;
                    if (sclk_reg) begin
                        if (frame_wrap) begin
                            bit_cnt_reg  <= '0;
                            shift_reg    <= frame_load;
                            fs_reg       <= 1'b1;
                            underrun_reg <= |(need_reg & ~accept_mask);
                        end else begin
                            bit_cnt_reg <= bit_cnt_reg + BIT_W'(1);
                            shift_reg   <= shift_reg << 1;
                            fs_reg      <= 1'b0;
                        end
                    end
                end else begin
                    div_cnt_reg <= div_cnt_reg + DIV_W'(1);
                end
            end
        end
    end

    assign s_tx_dr     = dr_reg;
    assign tdm_sclk    = sclk_reg;
    assign tdm_fs      = fs_reg;
    assign tdm_sd      = shift_reg[FRAME_BITS-1];
    assign tx_underrun = underrun_reg;
    assign tx_running  = (state_reg == RUN);

endmodule
